// File: rtl/demux1_4_16bit_buf.sv
// Registered 1-to-4 word distributor: each accepted word lands in one of four
// single-entry slots (A..D) and stays there until that slot's consumer acks it.
module demux1_4_16bit_buf #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      In,
    input  logic [1:0]       S,
    input  logic             InValid,
    output logic             InReady,
    output logic [15:0]      OutA,
    output logic [15:0]      OutB,
    output logic [15:0]      OutC,
    output logic [15:0]      OutD,
    output logic             ValA,
    output logic             ValB,
    output logic             ValC,
    output logic             ValD,
    input  logic             AckA,
    input  logic             AckB,
    input  logic             AckC,
    input  logic             AckD,
    output logic [CNT_W-1:0] Count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e      state_q [4];
    slot_state_e      state_d [4];
    logic [15:0]      data_q  [4];
    logic [15:0]      data_d  [4];
    logic [3:0]       ack;
    logic [3:0]       sel;
    logic [3:0]       val;
    logic             accept;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign ack = {AckD, AckC, AckB, AckA};

    // A slot being drained this cycle can take a new word at the same edge.
    assign InReady = (state_q[S] == EMPTY) | ack[S];
    assign accept  = InValid & InReady;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign sel[gi] = accept && (S == 2'(gi));
            assign val[gi] = (state_q[gi] == FULL);

            always_ff @(posedge clk) begin
                if (!rst) begin
                    state_q[gi] <= EMPTY;
                    data_q[gi]  <= 16'h0000;
                end else begin
                    state_q[gi] <= state_d[gi];
                    data_q[gi]  <= data_d[gi];
                end
            end

            always_comb begin
                state_d[gi] = state_q[gi];
                data_d[gi]  = data_q[gi];
                case (state_q[gi])
                    EMPTY: begin
                        if (sel[gi]) begin
                            state_d[gi] = FULL;
                            data_d[gi]  = In;
                        end
                    end
                    FULL: begin
                        if (sel[gi]) begin
                            data_d[gi] = In;
                        end else if (ack[gi]) begin
                            state_d[gi] = EMPTY;
                        end
                    end
                    default: state_d[gi] = EMPTY;
                endcase
            end
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        if (accept) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign OutA  = data_q[0];
    assign OutB  = data_q[1];
    assign OutC  = data_q[2];
    assign OutD  = data_q[3];
    assign ValA  = val[0];
    assign ValB  = val[1];
    assign ValC  = val[2];
    assign ValD  = val[3];
    assign Count = count_q;

endmodule

// File: tb/tb_demux1_4_16bit_buf.sv
// Directed plus randomized bench for demux1_4_16bit_buf against a slot-array model.
module tb_demux1_4_16bit_buf;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      in_w;
    logic [1:0]       s;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      out_a, out_b, out_c, out_d;
    logic             val_a, val_b, val_c, val_d;
    logic             ack_a, ack_b, ack_c, ack_d;
    logic [CNT_W-1:0] count;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: what each consumer slot currently holds.
    logic [15:0] m_out [4];
    logic        m_val [4];
    int          m_count;

    always #5 clk = ~clk;

    demux1_4_16bit_buf #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .In(in_w), .S(s), .InValid(in_valid), .InReady(in_ready),
        .OutA(out_a), .OutB(out_b), .OutC(out_c), .OutD(out_d),
        .ValA(val_a), .ValB(val_b), .ValC(val_c), .ValD(val_d),
        .AckA(ack_a), .AckB(ack_b), .AckC(ack_c), .AckD(ack_d),
        .Count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        logic [15:0] outs [4];
        logic        vals [4];
        outs = '{out_a, out_b, out_c, out_d};
        vals = '{val_a, val_b, val_c, val_d};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_val%0d", tag, i), 32'(vals[i]), 32'(m_val[i]));
            chk($sformatf("%s_out%0d", tag, i), 32'(outs[i]), 32'(m_out[i]));
        end
        chk($sformatf("%s_count", tag), 32'(count), 32'(m_count % (1 << CNT_W)));
    endtask

    // One clock cycle: drive, check InReady before the edge, advance model, check after.
    task automatic step(input string tag, input logic r, input logic [15:0] d,
                        input logic [1:0] sv, input logic v, input logic [3:0] ack);
        logic exp_ready;
        rst = r; in_w = d; s = sv; in_valid = v;
        {ack_d, ack_c, ack_b, ack_a} = ack;
        #1;
        exp_ready = !m_val[sv] || ack[sv];
        chk({tag, "_ready"}, 32'(in_ready), 32'(exp_ready));
        if (!r) begin
            for (int i = 0; i < 4; i++) begin
                m_val[i] = 1'b0;
                m_out[i] = 16'h0000;
            end
            m_count = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (v && exp_ready && int'(sv) == i) begin
                    m_out[i] = d;
                    m_val[i] = 1'b1;
                end else if (ack[i]) begin
                    m_val[i] = 1'b0;
                end
            end
            if (v && exp_ready) m_count = (m_count + 1) % (1 << CNT_W);
        end
        @(posedge clk);
        #1;
        check_all(tag);
        $display("step %s rst=%0b S=%0d In=%h InValid=%0b ack=%b -> count=%0d", tag, r, sv, d, v, ack, count);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_out[i] = 16'h0;
            m_val[i] = 1'b0;
        end
        m_count = 0;
        rst = 1'b0; in_w = '0; s = '0; in_valid = 1'b0;
        {ack_d, ack_c, ack_b, ack_a} = 4'b0;
        @(posedge clk);
        #1;

        // Reset with a pending word that must be discarded.
        step("reset", 1'b0, 16'hBEEF, 2'd2, 1'b1, 4'b0000);
        chk("reset_count_zero", 32'(count), 32'd0);

        // Fill all four slots.
        step("fillA", 1'b1, 16'h1111, 2'd0, 1'b1, 4'b0000);
        step("fillB", 1'b1, 16'h2222, 2'd1, 1'b1, 4'b0000);
        step("fillC", 1'b1, 16'h3333, 2'd2, 1'b1, 4'b0000);
        step("fillD", 1'b1, 16'h4444, 2'd3, 1'b1, 4'b0000);
        chk("fill_outD", 32'(out_d), 32'h4444);
        chk("fill_count", 32'(count), 32'd4);

        // Backpressure, then release via same-cycle ack.
        step("bp_hold", 1'b1, 16'h5555, 2'd0, 1'b1, 4'b0000);
        chk("bp_outA_held", 32'(out_a), 32'h1111);
        step("bp_ack", 1'b1, 16'h5555, 2'd0, 1'b1, 4'b0001);
        chk("bp_outA_new", 32'(out_a), 32'h5555);
        chk("bp_valA", 32'(val_a), 32'd1);
        chk("bp_count", 32'(count), 32'd5);

        // Streaming into B with AckB held high.
        for (int i = 0; i < 16; i++) begin
            step($sformatf("stream%0d", i), 1'b1, 16'(i), 2'd1, 1'b1, 4'b0010);
            chk($sformatf("stream%0d_outB", i), 32'(out_b), 32'(i));
        end

        // Counter wrap: 257 accepts after reset.
        step("wrap_rst", 1'b0, 16'h0, 2'd0, 1'b0, 4'b0000);
        for (int i = 0; i < 257; i++) begin
            step("wrap", 1'b1, 16'($urandom), 2'($urandom_range(0, 3)), 1'b1, 4'b1111);
        end
        chk("wrap_count", 32'(count), 32'd1);

        // Mid-operation reset with B and D full.
        step("mid_rst", 1'b0, 16'h0, 2'd0, 1'b0, 4'b0000);
        step("mid_fillB", 1'b1, 16'hB0B0, 2'd1, 1'b1, 4'b0000);
        step("mid_fillD", 1'b1, 16'hD0D0, 2'd3, 1'b1, 4'b0000);
        step("mid_pulse", 1'b0, 16'h7777, 2'd2, 1'b1, 4'b0010);
        chk("mid_valB", 32'(val_b), 32'd0);
        chk("mid_valD", 32'(val_d), 32'd0);
        step("mid_after", 1'b1, 16'h8888, 2'd2, 1'b1, 4'b0000);
        chk("mid_outC", 32'(out_c), 32'h8888);
        chk("mid_count", 32'(count), 32'd1);

        // Randomized traffic, occasional reset; producer holds word while stalled.
        begin
            logic [15:0] d;
            logic [1:0]  sv;
            logic        v;
            d = 16'($urandom); sv = 2'($urandom_range(0, 3)); v = 1'b0;
            for (int i = 0; i < 300; i++) begin
                logic r;
                logic stalled;
                r = ($urandom_range(0, 49) != 0);
                stalled = v && m_val[sv];
                if (!stalled || !r) begin
                    d  = 16'($urandom);
                    sv = 2'($urandom_range(0, 3));
                    v  = ($urandom_range(0, 3) != 0);
                end
                step("rand", r, d, sv, v, 4'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
